ahb3lite_copy_master: RTL and testbench
=======================================

# ahb3lite_copy_master

AHB-Lite bus master that copies a block of 32-bit words from one region of an AHB-Lite slave to another, one word at a time (read, then write). Sits directly upstream of `ahb3lite_sram1rw`: it drives the SRAM's slave port and consumes its `HRDATA`/`HREADYOUT`/`HRESP`. It is controlled by a simple start/length command interface from local control logic. Addressing is word-indexed, matching the SRAM's `HADDR`.

## Interface
- `ADDR_WIDTH`, 4, width of `HADDR`, `src_addr` and `dst_addr`; one address unit is one 32-bit word.
- `LEN_WIDTH`, `ADDR_WIDTH+1`, width of `len`.

Ports:
- `HCLK` in 1: single clock; all logic on the rising edge.
- `HRESET` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle command strobe; sampled only in IDLE.
- `src_addr` in ADDR_WIDTH: first source word address; latched on accepted `start`.
- `dst_addr` in ADDR_WIDTH: first destination word address; latched on accepted `start`.
- `len` in LEN_WIDTH: number of words to copy; latched on accepted `start`.
- `busy` out 1: high from the cycle after an accepted `start` until DONE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: high with `done` if the copy aborted on `HRESP`; holds until the next accepted `start`.
- `HADDR` out ADDR_WIDTH: bus address.
- `HWRITE` out 1: bus write enable.
- `HTRANS` out 2: `2'b10` (NONSEQ) in address phases, otherwise `2'b00` (IDLE).
- `HSIZE` out 3: constant `3'b010`.
- `HBURST` out 3: constant `3'b000`.
- `HPROT` out 4: constant `4'b0011`.
- `HWDATA` out 32: write data, driven in the write data phase.
- `HRDATA` in 32: read data from the slave.
- `HREADY` in 1: slave ready (`HREADYOUT` gated with the select).
- `HRESP` in 1: slave error response.

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, DONE.
- **IDLE**
  - Drives `HTRANS`=IDLE, `HWRITE`=0, `HADDR`=0.
  - On `start`: latch `src_addr`, `dst_addr` and `len`, clear the word counter, clear `err`.
  - If `len`==0, go to DONE; otherwise go to RD_ADDR.
- **RD_ADDR**
  - Drives `HTRANS`=NONSEQ, `HWRITE`=0, `HADDR`=src.
  - Move to RD_DATA on an edge where `HREADY`=1; otherwise hold all outputs.
- **RD_DATA**
  - Drives `HTRANS`=IDLE.
  - On an edge where `HREADY`=1, capture `HRDATA` into a 32-bit buffer, then go to WR_ADDR.
- **WR_ADDR**
  - Drives `HTRANS`=NONSEQ, `HWRITE`=1, `HADDR`=dst.
  - Advances on `HREADY`=1, as in RD_ADDR.
- **WR_DATA**
  - Drives `HTRANS`=IDLE and `HWDATA`=buffer; `HWDATA` stays stable until `HREADY`=1.
  - On `HREADY`=1: increment src, dst and the counter.
  - If counter+1==`len`, go to DONE; otherwise go to RD_ADDR.
- **DONE**
  - Pulse `done` for one cycle, drop `busy`, return to IDLE.
- **Address arithmetic:** src and dst increment modulo 2^ADDR_WIDTH and wrap silently (15→0 with the default width).
- **Error handling:** `HRESP`=1 in RD_DATA or WR_DATA sets `err`.
  - Wait for `HREADY`=1 (end of the two-cycle error response), then go to DONE.
  - No further transfers are issued.
  - A write whose read errored is never issued.
- **`start` while busy:** ignored, with no effect on the latched registers.
- **Overlapping regions:** the copy is forward-only; overlapping regions are not detected.

## Timing
- **Reset values:** `busy`=0, `done`=0, `err`=0, `HTRANS`=00, `HWRITE`=0, `HADDR`=0, `HWDATA`=0. State=IDLE.
- **Reset mid-copy:** forces these values at the next edge. The bus is left in an IDLE transfer.
- **Command timing:** `start` sampled at edge 0; RD_ADDR is driven in cycle 1, with `busy`=1 from cycle 1.
- **Throughput with a zero-wait slave:** 4 cycles per word. The last WR_DATA is in cycle 4·len, and `done` is high in cycle 4·len+1.
- **`len`=0:** `done` is high in cycle 1; `busy` never rises; no bus transfer occurs.
- **Wait states:** each `HREADY`=0 cycle adds one cycle to the state it occurs in.
- **Outputs:** all outputs are registered or decoded directly from the state; there is no combinational path from `HRDATA` to any output.

## Test plan
- **Single copy:** preload SRAM[1]=0xabcd1234; `start`, src=1, dst=5, len=1.
  - `done` is high in cycle 5.
  - SRAM[5]=0xabcd1234.
  - Bus shows exactly one read and one write.
- **Block copy:** preload SRAM[0..3]=0x11111111, 0x22222222, 0x33333333, 0x44444444; src=0, dst=8, len=4.
  - `done` is high in cycle 17.
  - SRAM[8..11] match the preloaded values.
- **Wrap-around:** src=14, dst=2, len=3, with SRAM[14]=0xA, [15]=0xB, [0]=0xC.
  - SRAM[2..4]=0xA, 0xB, 0xC.
- **Zero length and busy start:** `len`=0 gives `done` in cycle 1 with `HTRANS` always 00. A second `start` pulsed mid-copy of len=2 is ignored and exactly 2 words are copied.
- **Error abort:** the slave model returns ERROR on the second read of len=3.
  - `err`=1 together with `done`.
  - Only the first destination word is written; no NONSEQ appears after the error.
- **Reset mid-copy:** assert `HRESET` during WR_DATA of the first word.
  - All outputs reach reset values at the next edge.
  - A subsequent copy completes correctly.

Source files
------------

// File: rtl/ahb3lite_copy_master.sv
// AHB-Lite master that copies a block of 32-bit words, one read then one write per word.
// Outputs are decoded from state and registers only; HRDATA reaches nothing but the word buffer.
//
// state    | meaning
// IDLE     | waiting for start; bus idle
// RD_ADDR  | read address phase at src
// RD_DATA  | read data phase; HRDATA captured on HREADY
// WR_ADDR  | write address phase at dst
// WR_DATA  | write data phase; HWDATA driven from the buffer
// DONE     | one-cycle completion pulse
module ahb3lite_copy_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic                  HWRITE,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [31:0]           HWDATA,
    input  logic [31:0]           HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic [31:0]           buf_q, buf_d;
    logic                  err_q, err_d;
    logic [LEN_WIDTH-1:0]  cnt_inc;

    assign HSIZE   = 3'b010;
    assign HBURST  = 3'b000;
    assign HPROT   = 4'b0011;
    assign err     = err_q;
    assign cnt_inc = cnt_q + LEN_WIDTH'(1);

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        err_d   = err_q;
        busy    = 1'b0;
        done    = 1'b0;
        HTRANS  = 2'b00;
        HWRITE  = 1'b0;
        HADDR   = '0;
        HWDATA  = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    len_d   = len;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = (len == '0) ? S_DONE : S_RD_ADDR;
                end
            end
            S_RD_ADDR: begin
                busy   = 1'b1;
                HTRANS = 2'b10;
                HADDR  = src_q;
                if (HREADY) state_d = S_RD_DATA;
            end
            S_RD_DATA: begin
                busy = 1'b1;
                if (HRESP) err_d = 1'b1;
                // An errored read aborts before its write is ever issued.
                if (HREADY) begin
                    if (HRESP) begin
                        state_d = S_DONE;
                    end else begin
                        buf_d   = HRDATA;
                        state_d = S_WR_ADDR;
                    end
                end
            end
            S_WR_ADDR: begin
                busy   = 1'b1;
                HTRANS = 2'b10;
                HWRITE = 1'b1;
                HADDR  = dst_q;
                if (HREADY) state_d = S_WR_DATA;
            end
            S_WR_DATA: begin
                busy   = 1'b1;
                HWDATA = buf_q;
                if (HRESP) err_d = 1'b1;
                if (HREADY) begin
                    if (HRESP) begin
                        state_d = S_DONE;
                    end else begin
                        src_d   = src_q + ADDR_WIDTH'(1);
                        dst_d   = dst_q + ADDR_WIDTH'(1);
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == len_q) ? S_DONE : S_RD_ADDR;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ahb3lite_copy_master.sv
// Self-checking bench: an AHB-Lite word memory model with optional wait states and
// error injection, plus a forward-copy reference model of the expected memory image.
module tb_ahb3lite_copy_master;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  src_addr = '0, dst_addr = '0;
    logic [4:0]  len = '0;
    logic        busy, done, err;
    logic [3:0]  HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA, HRDATA;
    logic        HREADY, HRESP;

    always #5 HCLK = ~HCLK;

    ahb3lite_copy_master dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .src_addr(src_addr),
        .dst_addr(dst_addr), .len(len), .busy(busy), .done(done), .err(err),
        .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA), .HRDATA(HRDATA),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    // ---------------- slave memory model ----------------
    logic [31:0] mem [16];
    logic [31:0] pre_img [16];
    logic [31:0] exp_mem [16];
    logic        pre_load = 1'b0, clr_stats = 1'b0, wait_en = 1'b0;
    int          err_read_idx = 0;
    logic        dp_valid = 1'b0, dp_write = 1'b0, dp_err = 1'b0, err_stage = 1'b0, err_seen = 1'b0;
    logic [3:0]  dp_addr = '0;
    int          dp_wait = 0;
    int          rd_cnt = 0, wr_cnt = 0, after_err = 0, wait_total = 0, busy_cnt = 0, active_cnt = 0;

    assign HREADY = !(dp_valid && (dp_wait != 0 || (dp_err && !err_stage)));
    assign HRESP  = dp_valid && dp_err;
    assign HRDATA = (dp_valid && !dp_write && !dp_err && HREADY) ? mem[dp_addr] : 32'hDEAD_BEEF;

    always @(posedge HCLK) begin
        if (pre_load) for (int i = 0; i < 16; i++) mem[i] <= pre_img[i];
        if (busy) busy_cnt <= busy_cnt + 1;
        if (HTRANS != 2'b00) active_cnt <= active_cnt + 1;
        if (HRESET) begin
            dp_valid <= 1'b0; dp_err <= 1'b0; err_stage <= 1'b0; dp_wait <= 0;
        end else if (HREADY) begin
            if (dp_valid && dp_write && !dp_err) mem[dp_addr] <= HWDATA;
            if (HTRANS == 2'b10) begin
                dp_valid  <= 1'b1;
                dp_write  <= HWRITE;
                dp_addr   <= HADDR;
                err_stage <= 1'b0;
                if (err_seen) after_err <= after_err + 1;
                if (HWRITE) begin
                    wr_cnt  <= wr_cnt + 1;
                    dp_err  <= 1'b0;
                    dp_wait <= wait_en ? int'($urandom_range(0, 2)) : 0;
                end else begin
                    rd_cnt  <= rd_cnt + 1;
                    dp_err  <= (rd_cnt + 1 == err_read_idx);
                    dp_wait <= (wait_en && rd_cnt + 1 != err_read_idx) ? int'($urandom_range(0, 2)) : 0;
                end
            end else begin
                dp_valid <= 1'b0;
                dp_err   <= 1'b0;
            end
        end else begin
            wait_total <= wait_total + 1;
            if (dp_wait != 0) dp_wait <= dp_wait - 1;
            else err_stage <= 1'b1;
        end
        if (HRESP) err_seen <= 1'b1;
        if (clr_stats) begin
            rd_cnt <= 0; wr_cnt <= 0; after_err <= 0; wait_total <= 0;
            busy_cnt <= 0; active_cnt <= 0; err_seen <= 1'b0;
        end
    end

    // ---------------- reference model helpers ----------------
    task automatic randomize_image();
        for (int i = 0; i < 16; i++) exp_mem[i] = $urandom;
    endtask

    task automatic preload();
        for (int i = 0; i < 16; i++) pre_img[i] = exp_mem[i];
        @(negedge HCLK) pre_load = 1'b1;
        @(negedge HCLK) pre_load = 1'b0;
    endtask

    // Forward word-by-word copy with 4-bit wrapping addresses.
    task automatic model_copy(input logic [3:0] s, input logic [3:0] d, input int n);
        logic [3:0] si, di;
        for (int i = 0; i < n; i++) begin
            si = s + 4'(i);
            di = d + 4'(i);
            exp_mem[di] = exp_mem[si];
        end
    endtask

    function automatic int first_mem_diff();
        for (int i = 0; i < 16; i++) if (mem[i] !== exp_mem[i]) return i;
        return -1;
    endfunction

    // Pulses start; returns the cyc value seen in cycle 1 (first cycle after the sampling edge).
    task automatic issue_start(input logic [3:0] s, input logic [3:0] d, input logic [4:0] n, output int c0);
        @(negedge HCLK) clr_stats = 1'b1;
        @(negedge HCLK) begin
            clr_stats = 1'b0;
            src_addr = s; dst_addr = d; len = n; start = 1'b1;
        end
        @(negedge HCLK) start = 1'b0;
        c0 = cyc;
    endtask

    // Waits (bounded) for done; reports its cycle number, or -1 on timeout.
    task automatic wait_done(input int c0, input int spur, output int dcyc, output logic errv);
        int cy;
        dcyc = -1;
        errv = 1'b0;
        for (int k = 0; k < 400; k++) begin
            cy = cyc - c0 + 1;
            if (done === 1'b1) begin
                dcyc = cy;
                errv = err;
                break;
            end
            if (cy == spur) begin
                start = 1'b1; src_addr = 4'hF; dst_addr = 4'h7; len = 5'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge HCLK);
        end
        start = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        HRESET = 1'b1;
        repeat (3) @(negedge HCLK);
        checks++;
        if ({busy, done, err, HTRANS, HWRITE, HADDR, HWDATA} !== 42'd0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%b htrans=%b hwrite=%b haddr=%h hwdata=%h want all zero",
                     busy, done, err, HTRANS, HWRITE, HADDR, HWDATA);
        end
        checks++;
        if ({HSIZE, HBURST, HPROT} !== {3'b010, 3'b000, 4'b0011}) begin
            failures++;
            $display("FAIL reset_constants: hsize=%b hburst=%b hprot=%b want 010 000 0011", HSIZE, HBURST, HPROT);
        end
        @(negedge HCLK) HRESET = 1'b0;
    endtask

    task automatic test_single();
        int c0, dcyc, bad;
        logic errv;
        randomize_image();
        exp_mem[1] = 32'habcd1234;
        preload();
        issue_start(4'd1, 4'd5, 5'd1, c0);
        checks++;
        if (busy !== 1'b1 || HTRANS !== 2'b10 || HADDR !== 4'd1 || HWRITE !== 1'b0) begin
            failures++;
            $display("FAIL single_cycle1: busy=%b htrans=%b haddr=%h hwrite=%b want 1 10 1 0", busy, HTRANS, HADDR, HWRITE);
        end
        wait_done(c0, 0, dcyc, errv);
        model_copy(4'd1, 4'd5, 1);
        checks++;
        if (dcyc != 5 || errv !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_done: cycle=%0d err=%b busy=%b want 5 0 0", dcyc, errv, busy);
        end
        checks++;
        if (rd_cnt != 1 || wr_cnt != 1) begin
            failures++;
            $display("FAIL single_bus_count: reads=%0d writes=%0d want 1 1", rd_cnt, wr_cnt);
        end
        @(negedge HCLK);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL single_done_pulse: done=%b one cycle later want 0", done);
        end
        bad = first_mem_diff();
        checks++;
        if (bad != -1 || mem[5] !== 32'habcd1234) begin
            failures++;
            $display("FAIL single_mem: first bad index %0d, mem[5]=%h want abcd1234", bad, mem[5]);
        end
    endtask

    task automatic test_block();
        int c0, dcyc, bad;
        logic errv;
        randomize_image();
        exp_mem[0] = 32'h11111111; exp_mem[1] = 32'h22222222;
        exp_mem[2] = 32'h33333333; exp_mem[3] = 32'h44444444;
        preload();
        issue_start(4'd0, 4'd8, 5'd4, c0);
        wait_done(c0, 0, dcyc, errv);
        model_copy(4'd0, 4'd8, 4);
        checks++;
        if (dcyc != 17) begin
            failures++;
            $display("FAIL block_done_cycle: cycle=%0d want 17", dcyc);
        end
        bad = first_mem_diff();
        checks++;
        if (bad != -1 || mem[11] !== 32'h44444444) begin
            failures++;
            $display("FAIL block_mem: first bad index %0d, mem[11]=%h want 44444444", bad, mem[11]);
        end
    endtask

    task automatic test_wrap();
        int c0, dcyc;
        logic errv;
        randomize_image();
        exp_mem[14] = 32'hA; exp_mem[15] = 32'hB; exp_mem[0] = 32'hC;
        preload();
        issue_start(4'd14, 4'd2, 5'd3, c0);
        wait_done(c0, 0, dcyc, errv);
        model_copy(4'd14, 4'd2, 3);
        checks++;
        if (mem[2] !== 32'hA || mem[3] !== 32'hB || mem[4] !== 32'hC || first_mem_diff() != -1) begin
            failures++;
            $display("FAIL wrap_mem: mem[2..4]=%h %h %h want a b c (cycle %0d)", mem[2], mem[3], mem[4], dcyc);
        end
    endtask

    task automatic test_zero_len();
        int c0, dcyc;
        logic errv;
        issue_start(4'd3, 4'd9, 5'd0, c0);
        wait_done(c0, 0, dcyc, errv);
        repeat (3) @(negedge HCLK);
        checks++;
        if (dcyc != 1 || busy_cnt != 0 || active_cnt != 0) begin
            failures++;
            $display("FAIL zero_len: done cycle=%0d busy cycles=%0d active bus cycles=%0d want 1 0 0",
                     dcyc, busy_cnt, active_cnt);
        end
    endtask

    task automatic test_busy_start();
        int c0, dcyc, bad;
        logic errv;
        randomize_image();
        preload();
        issue_start(4'd4, 4'd12, 5'd2, c0);
        wait_done(c0, 3, dcyc, errv);
        model_copy(4'd4, 4'd12, 2);
        repeat (3) @(negedge HCLK);
        checks++;
        if (dcyc != 9 || rd_cnt != 2 || wr_cnt != 2) begin
            failures++;
            $display("FAIL busy_start: done cycle=%0d reads=%0d writes=%0d want 9 2 2", dcyc, rd_cnt, wr_cnt);
        end
        bad = first_mem_diff();
        checks++;
        if (bad != -1) begin
            failures++;
            $display("FAIL busy_start_mem: mem[%0d]=%h want %h", bad, mem[bad], exp_mem[bad]);
        end
    endtask

    task automatic test_error();
        int c0, dcyc, bad;
        logic errv;
        randomize_image();
        preload();
        err_read_idx = 2;
        issue_start(4'd6, 4'd10, 5'd3, c0);
        wait_done(c0, 0, dcyc, errv);
        model_copy(4'd6, 4'd10, 1);
        checks++;
        if (dcyc < 0 || errv !== 1'b1) begin
            failures++;
            $display("FAIL error_flag: done cycle=%0d err at done=%b want err 1", dcyc, errv);
        end
        repeat (3) @(negedge HCLK);
        checks++;
        if (wr_cnt != 1 || rd_cnt != 2 || after_err != 0) begin
            failures++;
            $display("FAIL error_bus: writes=%0d reads=%0d nonseq after error=%0d want 1 2 0", wr_cnt, rd_cnt, after_err);
        end
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL error_hold: err=%b after done want 1", err);
        end
        bad = first_mem_diff();
        checks++;
        if (bad != -1) begin
            failures++;
            $display("FAIL error_mem: mem[%0d]=%h want %h", bad, mem[bad], exp_mem[bad]);
        end
        err_read_idx = 0;
    endtask

    task automatic test_reset_mid();
        int c0, dcyc, bad;
        logic errv;
        randomize_image();
        preload();
        issue_start(4'd3, 4'd11, 5'd2, c0);
        repeat (3) @(negedge HCLK);
        checks++;
        if (HWDATA !== exp_mem[3] || HTRANS !== 2'b00 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_wrdata: hwdata=%h htrans=%b busy=%b want %h 00 1", HWDATA, HTRANS, busy, exp_mem[3]);
        end
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        checks++;
        if ({busy, done, err, HTRANS, HWRITE, HADDR, HWDATA} !== 42'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b err=%b htrans=%b hwrite=%b haddr=%h hwdata=%h want all zero",
                     busy, done, err, HTRANS, HWRITE, HADDR, HWDATA);
        end
        @(negedge HCLK) HRESET = 1'b0;
        issue_start(4'd3, 4'd11, 5'd2, c0);
        wait_done(c0, 0, dcyc, errv);
        model_copy(4'd3, 4'd11, 2);
        bad = first_mem_diff();
        checks++;
        if (dcyc != 9 || errv !== 1'b0 || bad != -1) begin
            failures++;
            $display("FAIL reset_mid_recopy: done cycle=%0d err=%b first bad index=%0d want 9 0 -1", dcyc, errv, bad);
        end
    endtask

    task automatic test_random();
        int c0, dcyc, bad, n, want;
        logic errv;
        logic [3:0] s, d;
        wait_en = 1'b1;
        for (int it = 0; it < 20; it++) begin
            randomize_image();
            preload();
            s = 4'($urandom_range(0, 15));
            d = 4'($urandom_range(0, 15));
            n = int'($urandom_range(0, 6));
            issue_start(s, d, 5'(n), c0);
            wait_done(c0, 0, dcyc, errv);
            model_copy(s, d, n);
            want = (n == 0) ? 1 : 4 * n + 1 + wait_total;
            checks++;
            if (dcyc != want || errv !== 1'b0 || busy_cnt != want - 1) begin
                failures++;
                $display("FAIL random_timing it=%0d len=%0d: done cycle=%0d err=%b busy cycles=%0d want %0d 0 %0d",
                         it, n, dcyc, errv, busy_cnt, want, want - 1);
            end
            bad = first_mem_diff();
            checks++;
            if (bad != -1) begin
                failures++;
                $display("FAIL random_mem it=%0d src=%0d dst=%0d len=%0d: mem[%0d]=%h want %h",
                         it, s, d, n, bad, mem[bad], exp_mem[bad]);
            end
        end
        wait_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_block();
        test_wrap();
        test_zero_len();
        test_busy_start();
        test_error();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
